// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a single shared 4-bit ALU.
// Runs one operation at a time: accept, wait ALU_LAT cycles, hold the result until the requester takes it.
`timescale 1ns/1ps

module alu_req_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid_0,
    output logic       req_ready_0,
    input  logic [2:0] req_func_0,
    input  logic [3:0] req_a_0,
    input  logic [3:0] req_b_0,
    output logic       resp_valid_0,
    input  logic       resp_ready_0,
    output logic [7:0] resp_data_0,
    input  logic       req_valid_1,
    output logic       req_ready_1,
    input  logic [2:0] req_func_1,
    input  logic [3:0] req_a_1,
    input  logic [3:0] req_b_1,
    output logic       resp_valid_1,
    input  logic       resp_ready_1,
    output logic [7:0] resp_data_1,
    output logic [2:0] alu_func,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_result,
    input  logic       alu_cout,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    output logic       busy,
    output logic [7:0] op_count
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             last_grant, last_grant_nxt;
    logic             grant_id, grant_id_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       alu_func_nxt;
    logic [3:0]       alu_a_nxt, alu_b_nxt;
    logic             resp_valid_0_nxt, resp_valid_1_nxt;
    logic [7:0]       resp_data_0_nxt, resp_data_1_nxt;
    logic [7:0]       op_count_nxt;
    logic             grant_sel;
    logic [7:0]       captured;
    logic             resp_taken;

    // Next-state, combinational ready and register updates for the transaction FSM
    always_comb begin
        state_nxt        = state;
        last_grant_nxt   = last_grant;
        grant_id_nxt     = grant_id;
        cnt_nxt          = cnt;
        alu_func_nxt     = alu_func;
        alu_a_nxt        = alu_a;
        alu_b_nxt        = alu_b;
        resp_valid_0_nxt = resp_valid_0;
        resp_valid_1_nxt = resp_valid_1;
        resp_data_0_nxt  = resp_data_0;
        resp_data_1_nxt  = resp_data_1;
        op_count_nxt     = op_count;
        req_ready_0      = 1'b0;
        req_ready_1      = 1'b0;
        // On a tie the requester that did not win last time is chosen
        grant_sel        = (req_valid_0 && req_valid_1) ? ~last_grant : req_valid_1;
        captured         = {1'b0, alu_zero, alu_overflow, alu_cout, alu_result};
        resp_taken       = grant_id ? resp_ready_1 : resp_ready_0;

        case (state)
            IDLE: begin
                req_ready_0 = req_valid_0 && !grant_sel;
                req_ready_1 = req_valid_1 && grant_sel;
                if (req_valid_0 || req_valid_1) begin
                    alu_func_nxt   = grant_sel ? req_func_1 : req_func_0;
                    alu_a_nxt      = grant_sel ? req_a_1 : req_a_0;
                    alu_b_nxt      = grant_sel ? req_b_1 : req_b_0;
                    grant_id_nxt   = grant_sel;
                    last_grant_nxt = grant_sel;
                    cnt_nxt        = CNT_W'(ALU_LAT - 1);
                    state_nxt      = EXEC;
                end
            end
            EXEC: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    if (grant_id) begin
                        resp_valid_1_nxt = 1'b1;
                        resp_data_1_nxt  = captured;
                    end else begin
                        resp_valid_0_nxt = 1'b1;
                        resp_data_0_nxt  = captured;
                    end
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_taken) begin
                    resp_valid_0_nxt = 1'b0;
                    resp_valid_1_nxt = 1'b0;
                    op_count_nxt     = op_count + 8'd1;
                    state_nxt        = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
            cnt          <= '0;
            alu_func     <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            resp_valid_0 <= 1'b0;
            resp_valid_1 <= 1'b0;
            resp_data_0  <= '0;
            resp_data_1  <= '0;
            op_count     <= '0;
        end else begin
            state        <= state_nxt;
            last_grant   <= last_grant_nxt;
            grant_id     <= grant_id_nxt;
            cnt          <= cnt_nxt;
            alu_func     <= alu_func_nxt;
            alu_a        <= alu_a_nxt;
            alu_b        <= alu_b_nxt;
            resp_valid_0 <= resp_valid_0_nxt;
            resp_valid_1 <= resp_valid_1_nxt;
            resp_data_0  <= resp_data_0_nxt;
            resp_data_1  <= resp_data_1_nxt;
            op_count     <= op_count_nxt;
        end
    end

    // Busy follows the registered state only
    assign busy = (state != IDLE);

endmodule
